// File: rtl/wb_sram_arb3.sv
// Three-master round-robin Wishbone arbiter in front of the shared SRAM controller slave.
// The grant is held for a whole cyc; a per-transfer watchdog errors out stuck transfers.
module wb_sram_arb3 #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 7
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  input  logic        m2_cyc_i,
  input  logic        m2_stb_i,
  input  logic        m2_we_i,
  input  logic [31:0] m2_adr_i,
  input  logic [3:0]  m2_sel_i,
  input  logic [31:0] m2_dat_i,
  output logic [31:0] m2_dat_o,
  output logic        m2_ack_o,
  output logic        m2_err_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [TW-1:0] WdogMax = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    last_q, last_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic [2:0]    err_q, err_d;

  logic [2:0]  req;
  logic [1:0]  win;
  logic        in_grant;
  logic        g_cyc, g_stb, g_we;
  logic [31:0] g_adr, g_dat;
  logic [3:0]  g_sel;
  logic [2:0]  gnt_oh;
  logic [2:0]  ack_vec;

  assign req = {m2_cyc_i & m2_stb_i, m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  // Search starts at last+1 (mod 3) and wraps around.
  always_comb begin
    case (last_q)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_sel = '0;
    g_dat = '0;
    case (gnt_q)
      2'd0: begin
        g_cyc = m0_cyc_i; g_stb = m0_stb_i; g_we  = m0_we_i;
        g_adr = m0_adr_i; g_sel = m0_sel_i; g_dat = m0_dat_i;
      end
      2'd1: begin
        g_cyc = m1_cyc_i; g_stb = m1_stb_i; g_we  = m1_we_i;
        g_adr = m1_adr_i; g_sel = m1_sel_i; g_dat = m1_dat_i;
      end
      2'd2: begin
        g_cyc = m2_cyc_i; g_stb = m2_stb_i; g_we  = m2_we_i;
        g_adr = m2_adr_i; g_sel = m2_sel_i; g_dat = m2_dat_i;
      end
      default: ;
    endcase
  end

  assign in_grant = (state_q == StGrant);
  assign gnt_oh   = 3'(3'b001 << gnt_q);

  assign s_cyc_o = in_grant & g_cyc;
  assign s_stb_o = in_grant & g_cyc & g_stb;
  assign s_we_o  = in_grant & g_we;
  assign s_adr_o = in_grant ? g_adr : '0;
  assign s_sel_o = in_grant ? g_sel : '0;
  assign s_dat_o = in_grant ? g_dat : '0;

  // Acks only pass through in GRANT, so a late ack in DRAIN is swallowed.
  assign ack_vec  = (in_grant && s_ack_i) ? gnt_oh : 3'b000;
  assign m0_ack_o = ack_vec[0];
  assign m1_ack_o = ack_vec[1];
  assign m2_ack_o = ack_vec[2];
  assign m0_err_o = err_q[0];
  assign m1_err_o = err_q[1];
  assign m2_err_o = err_q[2];
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m2_dat_o = s_dat_i;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    err_d   = 3'b000;
    case (state_q)
      StIdle: begin
        wdog_d = '0;
        if (|req) begin
          gnt_d   = win;
          last_d  = win;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!g_cyc) begin
          state_d = StIdle;
          wdog_d  = '0;
        end else if (g_stb && !s_ack_i) begin
          if ((TIMEOUT != 0) && (wdog_q == WdogMax)) begin
            err_d   = gnt_oh;
            wdog_d  = '0;
            state_d = StDrain;
          end else begin
            wdog_d = wdog_q + TW'(1);
          end
        end else begin
          wdog_d = '0;
        end
      end
      StDrain: begin
        if (s_ack_i || (wdog_q == WdogMax)) begin
          wdog_d  = '0;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
      end
      default: begin
        wdog_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= 2'd0;
      last_q  <= 2'd2;
      wdog_q  <= '0;
      err_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

endmodule
